axis_deadlock_monitor: RTL and testbench
========================================

# axis_deadlock_monitor

Parametrised deadlock monitor for HLS co-simulation benches. It watches N AXI-Stream block indicators and M sub-instance idle/block pairs, filters transient stalls with a configurable persistence threshold, and raises `block` only after a continuous stall. It also captures which sources were stalling and counts how long the stall lasted. One instance sits per monitored top or sub-module, and its `block` feeds the parent monitor's `inst_block_sigs`.

## Interface
Parameters:
- `NUM_AXIS`, 2: number of AXI-Stream block inputs (≥1).
- `NUM_INST`, 1: number of monitored sub-instances (≥1).
- `THRESH`, 16: consecutive raw-block cycles required before `block` asserts (≥1).
- `CYC_W`, 16: width of the stall-duration counter.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `axis_block_sigs`  in  NUM_AXIS  per-channel stream stall.
- `inst_idle_sigs`  in  NUM_INST  per-instance idle.
- `inst_block_sigs`  in  NUM_INST  per-instance block.
- `clear`  in  1  synchronous clear of monitor state.
- `block`  out  1  deadlock declared.
- `block_src`  out  NUM_AXIS+NUM_INST  snapshot of `{inst_block_sigs, axis_block_sigs}` at declaration.
- `block_cycles`  out  CYC_W  cycles spent in BLOCKED, saturating.

## Operation
- `sub_block` = (AND over i of (`inst_idle_sigs[i]` | `inst_block_sigs[i]`)) & (OR of `inst_block_sigs`). It is true only when every instance is idle or blocked and at least one is blocked.
- `raw` = (OR of `axis_block_sigs`) | `sub_block`. This is combinational and unregistered.
- States:
  - IDLE: `cnt`=0.
    - `raw`=1 and THRESH=1 → BLOCKED.
    - `raw`=1 and THRESH>1 → PENDING with `cnt`=1.
  - PENDING:
    - `raw`=0 → IDLE, `cnt`=0.
    - `raw`=1 and `cnt`==THRESH-1 → BLOCKED.
    - Otherwise `cnt`++.
  - BLOCKED: see Configuration for the exit rule.
- On entry to BLOCKED: `block_src` ← current `{inst_block_sigs, axis_block_sigs}`, and `block_cycles` ← 1.
- While in BLOCKED: `block_cycles` increments each cycle and saturates at 2^CYC_W-1.
- `block` = (state == BLOCKED). It is decoded from registered state.
- `block_src` and `block_cycles` hold their values after leaving BLOCKED and update only on the next entry, on `clear`, or on `reset`.
- `cnt` width is clog2(THRESH+1).

## Timing
- Reset values: state IDLE, `cnt`=0, `block`=0, `block_src`=0, `block_cycles`=0.
- Latency: if `raw` rises in cycle k and stays high, `block` is 1 from cycle k+THRESH.
  - THRESH=1 gives a one-cycle registered response.
- A single `raw`=0 cycle in PENDING restarts the count. There is no partial credit.
- Priority: `reset` > `clear` > FSM transition.
- `clear` forces IDLE and zeros `cnt`, `block_src` and `block_cycles` in the next cycle.
  - `raw` in the clear cycle is ignored.
  - If `raw` is still high, counting restarts in the following cycle.
- `reset` mid-PENDING or mid-BLOCKED returns all outputs to reset values on the next edge.
- Input changes in the entry cycle are captured as sampled at that edge. There is no double sampling.

## Configuration
- `DEADLOCK_MON_STICKY_EN` defined: BLOCKED is sticky.
  - It exits only on `clear` or `reset`, even if `raw` falls.
  - `block_cycles` keeps counting while in BLOCKED.
- Undefined: BLOCKED → IDLE in the cycle after `raw`=0 is sampled.
  - `block` falls one cycle after `raw` falls.
  - `block_cycles` freezes at its last value.

## Structure
- Shared package `deadlock_mon_pkg` holds:
  - the state enum `dl_state_t` (IDLE, PENDING, BLOCKED);
  - the default `THRESH`/`CYC_W` constants;
  - a `clog2`-style width function, if the codebase lacks one.
- A single sub-module `deadlock_sub_reduce` is natural. It is combinational and computes `sub_block` from `inst_idle_sigs`/`inst_block_sigs`, so the reduction can be reused by generated parent monitors.
- The FSM, counters and capture stay in the top.

## Test plan
- THRESH=4, `axis_block_sigs`=2'b01 held 3 cycles then 0 → `block` never asserts; `cnt` returns to 0.
- THRESH=4, `axis_block_sigs`=2'b10 held from cycle 10 → `block`=1 from cycle 14, `block_src`=3'b010, `block_cycles`=1 at cycle 14 and 5 at cycle 18.
- NUM_INST=2, `inst_idle_sigs`=2'b01, `inst_block_sigs`=2'b10 held, THRESH=1 → `block`=1 next cycle, `block_src`=4'b1000. Then set `inst_idle_sigs`=2'b00, `inst_block_sigs`=2'b10 → `sub_block`=0, so `raw`=0.
- Non-sticky build, stall cleared at cycle 20 → `block`=0 at cycle 21. Sticky build, same stimulus → `block` stays 1 until `clear` is pulsed at cycle 30, then `block`=0 at cycle 31 with all outputs 0.
- CYC_W=4, stall held 40 cycles in sticky build → `block_cycles` saturates at 15.
- `reset` asserted in mid-PENDING and again in mid-BLOCKED → all outputs 0 on the next edge; a new stall needs the full THRESH again.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the deadlock monitor family: FSM state encoding,
// default threshold/counter widths and a constant width helper.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLOCKED = 2'd2
  } dl_state_t;

  localparam int DEFAULT_THRESH = 16;
  localparam int DEFAULT_CYC_W  = 16;

  // Number of bits needed to encode values 0 .. value-1 (ceil(log2(value))).
  function automatic int dl_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if (longint'(value) > (longint'(1) << i)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/deadlock_sub_reduce.sv
// Sub-instance stall reduction: true only when every monitored instance is
// either idle or blocked and at least one of them is blocked. Kept separate
// so generated parent monitors can reuse the same reduction.
module deadlock_sub_reduce #(
  parameter int NUM_INST = 1
) (
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                sub_block
);

  logic all_quiet;
  logic any_blocked;

  assign all_quiet   = &(inst_idle_sigs | inst_block_sigs);
  assign any_blocked = |inst_block_sigs;
  assign sub_block   = all_quiet & any_blocked;

endmodule

// File: rtl/axis_deadlock_monitor.sv
// Deadlock monitor for HLS co-simulation. A raw stall indication (any stream
// stall, or all sub-instances quiet with at least one blocked) must persist for
// THRESH consecutive cycles before block is declared. On declaration the
// stalling sources are snapshotted and the stall duration is counted.
//
// Build option: define DEADLOCK_MON_STICKY_EN to make BLOCKED sticky (left only
// by clear or reset). Without it, BLOCKED returns to IDLE one cycle after the
// raw stall disappears and block_cycles freezes.
module axis_deadlock_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1,
  parameter int THRESH   = DEFAULT_THRESH,
  parameter int CYC_W    = DEFAULT_CYC_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_INST-1:0]          inst_idle_sigs,
  input  logic [NUM_INST-1:0]          inst_block_sigs,
  input  logic                         clear,
  output logic                         block,
  output logic [NUM_AXIS+NUM_INST-1:0] block_src,
  output logic [CYC_W-1:0]             block_cycles
);

  localparam int                SRC_W    = NUM_AXIS + NUM_INST;
  localparam int                CNT_W    = dl_clog2(THRESH + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(THRESH - 1);
  localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);
  localparam logic [CYC_W-1:0]  CYC_MAX  = {CYC_W{1'b1}};
  localparam bit                SINGLE   = (THRESH == 1);

  logic             sub_block;
  logic             raw;
  logic [SRC_W-1:0] src_now;
  logic [CYC_W-1:0] cycles_next;
  dl_state_t        state;
  logic [CNT_W-1:0] cnt;

  deadlock_sub_reduce #(
    .NUM_INST (NUM_INST)
  ) u_sub_reduce (
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .sub_block       (sub_block)
  );

  assign raw         = (|axis_block_sigs) | sub_block;
  assign src_now     = {inst_block_sigs, axis_block_sigs};
  assign cycles_next = (block_cycles == CYC_MAX) ? CYC_MAX : block_cycles + CYC_ONE;

  // Persistence FSM with stall-source capture and saturating duration counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      block_src    <= '0;
      block_cycles <= '0;
    end else if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      block_src    <= '0;
      block_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (raw) begin
            if (SINGLE) begin
              state        <= BLOCKED;
              block_src    <= src_now;
              block_cycles <= CYC_ONE;
            end else begin
              state <= PENDING;
              cnt   <= CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (!raw) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= BLOCKED;
            cnt          <= '0;
            block_src    <= src_now;
            block_cycles <= CYC_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        BLOCKED: begin
          cnt <= '0;
`ifdef DEADLOCK_MON_STICKY_EN
          block_cycles <= cycles_next;
`else
          if (raw) begin
            block_cycles <= cycles_next;
          end else begin
            state <= IDLE;
          end
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign block = (state == BLOCKED);

endmodule

// File: tb/tb_axis_deadlock_monitor.sv
// Bench for axis_deadlock_monitor: two instances (THRESH=4/CYC_W=4 and
// THRESH=1/CYC_W=16) share stimulus; a behavioural run-length model predicts
// every cycle, expectations are queued at drive time and popped after the edge.
module tb_axis_deadlock_monitor;

`ifdef DEADLOCK_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam int THRESH_A = 4;
  localparam int CMAX_A   = 15;
  localparam int THRESH_B = 1;
  localparam int CMAX_B   = 65535;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic [1:0]  axis;
  logic [1:0]  idle;
  logic [1:0]  iblk;

  logic        blk_a;
  logic [3:0]  src_a;
  logic [3:0]  cyc_a;
  logic        blk_b;
  logic [3:0]  src_b;
  logic [15:0] cyc_b;

  always #5 clock = ~clock;

  axis_deadlock_monitor #(
    .NUM_AXIS (2), .NUM_INST (2), .THRESH (THRESH_A), .CYC_W (4)
  ) dut_a (
    .clock (clock), .reset (reset), .axis_block_sigs (axis),
    .inst_idle_sigs (idle), .inst_block_sigs (iblk), .clear (clear),
    .block (blk_a), .block_src (src_a), .block_cycles (cyc_a)
  );

  axis_deadlock_monitor #(
    .NUM_AXIS (2), .NUM_INST (2), .THRESH (THRESH_B), .CYC_W (16)
  ) dut_b (
    .clock (clock), .reset (reset), .axis_block_sigs (axis),
    .inst_idle_sigs (idle), .inst_block_sigs (iblk), .clear (clear),
    .block (blk_b), .block_src (src_b), .block_cycles (cyc_b)
  );

  typedef struct {
    logic        blk_a;
    logic [3:0]  src_a;
    logic [3:0]  cyc_a;
    logic        blk_b;
    logic [3:0]  src_b;
    logic [15:0] cyc_b;
  } exp_t;

  typedef struct {
    logic [1:0] axis;
    logic [1:0] idle;
    logic [1:0] iblk;
    logic       clr;
    logic       rst;
    int         reps;
    logic       chk;
    logic       exp_blk_a;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  logic       m_blk_a, m_blk_b;
  int         m_run_a, m_run_b;
  logic [3:0] m_src_a, m_src_b;
  int         m_cyc_a, m_cyc_b;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic stepModel(input int thresh, input int cmax, input logic raw,
                           input logic [3:0] snap, inout logic blk, inout int run,
                           inout logic [3:0] src, inout int cyc);
    if (blk) begin
      run = 0;
      if (raw || STICKY) cyc = (cyc < cmax) ? cyc + 1 : cyc;
      else blk = 1'b0;
    end else if (raw) begin
      run++;
      if (run >= thresh) begin
        blk = 1'b1;
        src = snap;
        cyc = 1;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL scoreboard: queue empty at %0t", $time);
      return;
    end
    e = sb_q.pop_front();
    check("a.block",        16'(blk_a), 16'(e.blk_a));
    check("a.block_src",    16'(src_a), 16'(e.src_a));
    check("a.block_cycles", 16'(cyc_a), 16'(e.cyc_a));
    check("b.block",        16'(blk_b), 16'(e.blk_b));
    check("b.block_src",    16'(src_b), 16'(e.src_b));
    check("b.block_cycles", cyc_b,      e.cyc_b);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic all_ok, any_blk, raw;
    exp_t e;
    for (int r = 0; r < v.reps; r++) begin
      axis  = v.axis;
      idle  = v.idle;
      iblk  = v.iblk;
      clear = v.clr;
      reset = v.rst;
      all_ok  = 1'b1;
      any_blk = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!idle[i] && !iblk[i]) all_ok = 1'b0;
        if (iblk[i]) any_blk = 1'b1;
      end
      raw = (axis != 2'b00) || (all_ok && any_blk);
      if (v.rst || v.clr) begin
        m_blk_a = 1'b0; m_run_a = 0; m_src_a = '0; m_cyc_a = 0;
        m_blk_b = 1'b0; m_run_b = 0; m_src_b = '0; m_cyc_b = 0;
      end else begin
        stepModel(THRESH_A, CMAX_A, raw, {iblk, axis}, m_blk_a, m_run_a, m_src_a, m_cyc_a);
        stepModel(THRESH_B, CMAX_B, raw, {iblk, axis}, m_blk_b, m_run_b, m_src_b, m_cyc_b);
      end
      e.blk_a = m_blk_a; e.src_a = m_src_a; e.cyc_a = 4'(m_cyc_a);
      e.blk_b = m_blk_b; e.src_b = m_src_b; e.cyc_b = 16'(m_cyc_b);
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      checkOutput();
    end
    if (v.chk) check("a.block_table", 16'(blk_a), 16'(v.exp_blk_a));
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; clear = 1'b0; axis = '0; idle = '0; iblk = '0;

    //               axis   idle   iblk   clr   rst   reps chk  exp_a
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1,  1'b1, 1'b1});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 4,  1'b1, 1'b1});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1,  1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 40, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2,  1'b0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1,  1'b1, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1,  1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 3,  1'b1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 1,  1'b1, 1'b1});

    $display("[TB] directed table: %0d entries, sticky=%0d", tbl.size(), STICKY);
    foreach (tbl[i]) applyStimulus(tbl[i]);

    $display("[TB] random phase");
    for (int k = 0; k < 120; k++) begin
      v.axis      = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      v.idle      = 2'($urandom_range(0, 3));
      v.iblk      = 2'($urandom_range(0, 3));
      v.clr       = ($urandom_range(0, 24) == 0);
      v.rst       = ($urandom_range(0, 49) == 0);
      v.reps      = $urandom_range(1, 7);
      v.chk       = 1'b0;
      v.exp_blk_a = 1'b0;
      applyStimulus(v);
    end

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
